// File: rtl/sensor_inject_pkg.sv
// Shared types and constants for the sensor-inject replay engine.
// Holds default geometry, FSM encoding and status bit layout.
package sensor_inject_pkg;

  localparam int DEF_DEPTH_BYTES = 4096;
  localparam int DEF_DW = 64;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEF_DW);
  localparam int WORD_AW = $clog2(DEF_DEPTH_BYTES / BYTES_PER_WORD);
  localparam int BYTE_AW = $clog2(DEF_DEPTH_BYTES);

  localparam int STAT_W = 1;
  localparam int STAT_ERR = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/sensor_inject_ram.sv
// Simple dual-port replay buffer: byte-enabled write port A,
// registered read port B.
module sensor_inject_ram
  import sensor_inject_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int DEPTH_WORDS = DEF_DEPTH_BYTES / BYTES_PER_WORD,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic [DW/8-1:0] we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (we[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sensor_inject_player.sv
// Captures loaded bytes and replays them as AXI-Stream frames.
// Define SENSOR_INJECT_LOOP_EN for back-to-back looping while run is held.
module sensor_inject_player
  import sensor_inject_pkg::*;
#(
  parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_fifo_clear,
  input  logic          i_fifo_clear_wstrobe,
  input  logic [7:0]    i_load_data,
  input  logic          i_load_wstrobe,
  input  logic          i_run,
  output logic [31:0]   o_fifo_count,
  output logic          o_fifo_status,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  output logic          axis_out_tlast,
  input  logic          axis_out_tready,
  output logic          o_busy
);

  localparam int BPW = bytes_per_word(DW);
  localparam int LB = $clog2(BPW);
  localparam int WAW = $clog2(DEPTH_BYTES / BPW);
  localparam int CW = $clog2(DEPTH_BYTES) + 1;

`ifdef SENSOR_INJECT_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t state, state_nx;

  logic [CW-1:0]     count;
  logic [STAT_W-1:0] status;
  logic              clr_pend, armed, issue_done;
  logic [WAW-1:0]    rd_word;
  logic              rv, rl;
  logic [DW-1:0]     ram_q, in_data;
  logic              out_valid, out_last, sk_valid, sk_last;
  logic [DW-1:0]     out_data, sk_data;

  logic          clr_strb, clr_req, clr_apply;
  logic          ld_ok, ld_err, pop, frame_end;
  logic          keep_going, flush, start, issue, is_last;
  logic [CW-1:0] nwords, last_idx, lane, lastn;
  logic [1:0]    occ;
  logic [BPW-1:0] be;

  always_comb begin
    clr_strb = i_fifo_clear_wstrobe & i_fifo_clear;
    clr_req = clr_strb | clr_pend;
    clr_apply = clr_req & ((state == ST_IDLE) | (state == ST_FETCH) |
                           !out_valid | axis_out_tready);
    pop = out_valid & axis_out_tready;
    frame_end = pop & out_last;
    keep_going = LOOP_EN & i_run;
    flush = clr_apply | (frame_end & !keep_going);
    start = (state == ST_IDLE) & i_run & armed &
            (count != '0) & !clr_req;
    nwords = (count + CW'(BPW - 1)) >> LB;
    last_idx = nwords - CW'(1);
    is_last = ({{(CW-WAW){1'b0}}, rd_word} == last_idx);
    occ = 2'(out_valid) + 2'(sk_valid) + 2'(rv) - 2'(pop);
    issue = ((state == ST_FETCH) | (state == ST_STREAM)) &
            !issue_done & (occ <= 2'd1) & !flush;
    ld_ok = i_load_wstrobe & !clr_strb & (state == ST_IDLE) &
            (count != CW'(DEPTH_BYTES));
    ld_err = i_load_wstrobe & !clr_strb & !ld_ok;
    lane = count & CW'(BPW - 1);
    be = ld_ok ? (BPW'(1) << lane) : '0;
  end

  // Bytes past the loaded count in the final word are forced to zero.
  always_comb begin
    lastn = count & CW'(BPW - 1);
    in_data = ram_q;
    for (int b = 0; b < BPW; b++) begin
      if (rl && (lastn != '0) && (CW'(b) >= lastn))
        in_data[b*8 +: 8] = 8'h00;
    end
  end

  sensor_inject_ram #(
    .DW(DW),
    .DEPTH_WORDS(DEPTH_BYTES / BPW),
    .AW(WAW)
  ) u_ram (
    .clk(clk),
    .we(be),
    .waddr(WAW'(count >> LB)),
    .wdata({BPW{i_load_data}}),
    .re(issue),
    .raddr(rd_word),
    .rdata(ram_q)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_STREAM;
      ST_STREAM: if (frame_end && !keep_going) state_nx = ST_DRAIN;
      ST_DRAIN:  if (!out_valid && !sk_valid && !rv) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (clr_apply) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
      status <= '0;
      clr_pend <= 1'b0;
      armed <= 1'b0;
      issue_done <= 1'b0;
      rd_word <= '0;
      rv <= 1'b0;
      rl <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      sk_valid <= 1'b0;
      sk_last <= 1'b0;
      sk_data <= '0;
    end else begin
      if (ld_ok) count <= count + CW'(1);
      if (ld_err) status[STAT_ERR] <= 1'b1;
      clr_pend <= clr_req & !clr_apply;
      rv <= issue;
      rl <= is_last;

      if (state == ST_IDLE) begin
        rd_word <= '0;
        issue_done <= 1'b0;
        if (start)       armed <= 1'b0;
        else if (!i_run) armed <= 1'b1;
      end else if (issue) begin
        rd_word <= is_last ? '0 : rd_word + WAW'(1);
        if (is_last && !LOOP_EN) issue_done <= 1'b1;
      end

      // Two-entry skid: head drives the bus, second slot absorbs prefetch.
      if (flush) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
        sk_valid <= 1'b0;
      end else if (out_valid && !pop) begin
        if (!sk_valid && rv) begin
          sk_valid <= 1'b1;
          sk_data <= in_data;
          sk_last <= rl;
        end
      end else if (sk_valid) begin
        out_valid <= 1'b1;
        out_data <= sk_data;
        out_last <= sk_last;
        sk_valid <= rv;
        sk_data <= in_data;
        sk_last <= rl;
      end else begin
        out_valid <= rv;
        if (rv) begin
          out_data <= in_data;
          out_last <= rl;
        end
      end

      if (clr_apply) begin
        count <= '0;
        status <= '0;
      end
    end
  end

  assign o_fifo_count = 32'(count);
  assign o_fifo_status = status[STAT_ERR];
  assign axis_out_tdata = out_data;
  assign axis_out_tvalid = out_valid;
  assign axis_out_tlast = out_last;
  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sensor_inject_player.sv
// Directed + randomized bench for sensor_inject_player with a
// byte-queue reference model of the replay buffer.
module tb_sensor_inject_player;

  localparam int DEPTH = 4096;
  localparam int DW = 64;
  localparam int BPW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          i_fifo_clear, i_fifo_clear_wstrobe;
  logic [7:0]    i_load_data;
  logic          i_load_wstrobe, i_run;
  logic [31:0]   o_fifo_count;
  logic          o_fifo_status;
  logic [DW-1:0] axis_out_tdata;
  logic          axis_out_tvalid, axis_out_tlast, axis_out_tready;
  logic          o_busy;

  always #5 clk = ~clk;

  sensor_inject_player dut (
    .clk(clk),
    .resetn(resetn),
    .i_fifo_clear(i_fifo_clear),
    .i_fifo_clear_wstrobe(i_fifo_clear_wstrobe),
    .i_load_data(i_load_data),
    .i_load_wstrobe(i_load_wstrobe),
    .i_run(i_run),
    .o_fifo_count(o_fifo_count),
    .o_fifo_status(o_fifo_status),
    .axis_out_tdata(axis_out_tdata),
    .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tlast(axis_out_tlast),
    .axis_out_tready(axis_out_tready),
    .o_busy(o_busy)
  );

  int checks = 0;
  int passed = 0;
  logic [7:0]  q[$];
  bit          mstat;
  bit          rmode;
  logic [63:0] got_d[$];
  bit          got_l[$];
  logic        pv, pr;
  logic [63:0] pd;
  logic [63:0] w0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (pv && !pr) begin
        check("hold_valid", 64'(axis_out_tvalid), 64'd1);
        check("hold_data", axis_out_tdata, pd);
      end
      if (axis_out_tvalid && axis_out_tready) begin
        got_d.push_back(axis_out_tdata);
        got_l.push_back(axis_out_tlast);
      end
    end
    pv <= axis_out_tvalid;
    pr <= axis_out_tready;
    pd <= axis_out_tdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode) axis_out_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input logic [7:0] b, input bit playing);
    i_load_data = b;
    i_load_wstrobe = 1'b1;
    tick();
    i_load_wstrobe = 1'b0;
    if (playing || q.size() == DEPTH) mstat = 1'b1;
    else q.push_back(b);
  endtask

  task automatic clear_fifo();
    i_fifo_clear = 1'b1;
    i_fifo_clear_wstrobe = 1'b1;
    tick();
    i_fifo_clear_wstrobe = 1'b0;
    i_fifo_clear = 1'b0;
    q.delete();
    mstat = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (o_busy && c < 5000) begin
      tick();
      c++;
    end
    check(tag, 64'(o_busy), 64'd0);
  endtask

  function automatic logic [63:0] exp_word(input int i);
    logic [63:0] w = '0;
    for (int b = 0; b < BPW; b++) begin
      if (i * BPW + b < q.size()) w[b*8 +: 8] = q[i*BPW + b];
    end
    return w;
  endfunction

  task automatic compare_frame(input string tag);
    int nw = (q.size() + BPW - 1) / BPW;
`ifdef SENSOR_INJECT_LOOP_EN
    check({tag, "_nbeats_mod"}, 64'(got_d.size() % nw), 64'd0);
    check({tag, "_nbeats_min"}, 64'(got_d.size() >= nw), 64'd1);
`else
    check({tag, "_nbeats"}, 64'(got_d.size()), 64'(nw));
`endif
    for (int i = 0; i < got_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_d[i], exp_word(i % nw));
      check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]),
            64'((i % nw) == nw - 1));
    end
  endtask

  task automatic run_pulse();
    got_d.delete();
    got_l.delete();
    i_run = 1'b1;
    tick();
    i_run = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    i_fifo_clear = 1'b0;
    i_fifo_clear_wstrobe = 1'b0;
    i_load_data = '0;
    i_load_wstrobe = 1'b0;
    i_run = 1'b0;
    axis_out_tready = 1'b1;
    rmode = 1'b0;
    mstat = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", 64'(axis_out_tvalid), 64'd0);
    check("rst_tlast", 64'(axis_out_tlast), 64'd0);
    check("rst_tdata", axis_out_tdata, 64'd0);
    check("rst_count", 64'(o_fifo_count), 64'd0);
    check("rst_status", 64'(o_fifo_status), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // 16-byte ramp, run held high
    for (int i = 1; i <= 16; i++) load(8'(i), 1'b0);
    check("t1_count", 64'(o_fifo_count), 64'd16);
    got_d.delete();
    got_l.delete();
    i_run = 1'b1;
    repeat (2) tick();
    check("t1_busy", 64'(o_busy), 64'd1);
`ifdef SENSOR_INJECT_LOOP_EN
    repeat (20) tick();
    i_run = 1'b0;
    wait_idle("t1_idle");
`else
    wait_idle("t1_idle");
    repeat (4) tick();
    check("t1_no_rerun", 64'(o_busy), 64'd0);
    i_run = 1'b0;
`endif
    check("t1_beat0", got_d.size() > 0 ? got_d[0] : 64'd0,
          64'h0807060504030201);
    check("t1_beat1", got_d.size() > 1 ? got_d[1] : 64'd0,
          64'h100F0E0D0C0B0A09);
    compare_frame("t1");
    repeat (2) tick();

    // 5-byte partial word, single pulse
    clear_fifo();
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i), 1'b0);
    tick();
    run_pulse();
    tick();
    check("t2_busy", 64'(o_busy), 64'd1);
    check("t2_count_play", 64'(o_fifo_count), 64'd5);
    wait_idle("t2_idle");
    check("t2_count_end", 64'(o_fifo_count), 64'd5);
    check("t2_beat", got_d.size() > 0 ? got_d[0] : 64'd0,
          64'h000000A4A3A2A1A0);
    compare_frame("t2");

    // fill to capacity, overflow, clear handling
    clear_fifo();
    for (int i = 0; i < DEPTH; i++) load(8'($urandom), 1'b0);
    check("t3_full", 64'(o_fifo_count), 64'(DEPTH));
    check("t3_stat0", 64'(o_fifo_status), 64'(mstat));
    load(8'h77, 1'b0);
    check("t3_ovf_count", 64'(o_fifo_count), 64'(q.size()));
    check("t3_ovf_stat", 64'(o_fifo_status), 64'd1);
    i_fifo_clear_wstrobe = 1'b1;
    tick();
    i_fifo_clear_wstrobe = 1'b0;
    check("t3_noclr_count", 64'(o_fifo_count), 64'(DEPTH));
    check("t3_noclr_stat", 64'(o_fifo_status), 64'd1);
    i_fifo_clear = 1'b1;
    i_fifo_clear_wstrobe = 1'b1;
    i_load_wstrobe = 1'b1;
    tick();
    i_fifo_clear = 1'b0;
    i_fifo_clear_wstrobe = 1'b0;
    i_load_wstrobe = 1'b0;
    q.delete();
    mstat = 1'b0;
    check("t3_clr_count", 64'(o_fifo_count), 64'd0);
    check("t3_clr_stat", 64'(o_fifo_status), 64'd0);

    // random lengths under random backpressure
    rmode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n = (k == 0) ? int'($urandom_range(1, 300)) : (k == 1) ? 64 : 1;
      clear_fifo();
      for (int i = 0; i < n; i++) load(8'($urandom), 1'b0);
      run_pulse();
      wait_idle($sformatf("t4_idle%0d", k));
      compare_frame($sformatf("t4_%0d", k));
    end

    // load attempt while streaming
    clear_fifo();
    for (int i = 0; i < 40; i++) load(8'($urandom), 1'b0);
    run_pulse();
    tick();
    load(8'h5A, 1'b1);
    check("t5_count", 64'(o_fifo_count), 64'd40);
    check("t5_stat", 64'(o_fifo_status), 64'(mstat));
    wait_idle("t5_idle");
    compare_frame("t5");
    check("t5_stat_end", 64'(o_fifo_status), 64'd1);

    // clear while a beat is stalled
    rmode = 1'b0;
    axis_out_tready = 1'b0;
    clear_fifo();
    for (int i = 0; i < 64; i++) load(8'($urandom), 1'b0);
    w0 = exp_word(0);
    got_d.delete();
    got_l.delete();
    i_run = 1'b1;
    begin
      int c = 0;
      while (!axis_out_tvalid && c < 20) begin
        tick();
        c++;
      end
    end
    i_run = 1'b0;
    check("t6_tvalid", 64'(axis_out_tvalid), 64'd1);
    clear_fifo();
    tick();
    check("t6_held_valid", 64'(axis_out_tvalid), 64'd1);
    check("t6_held_data", axis_out_tdata, w0);
    check("t6_held_busy", 64'(o_busy), 64'd1);
    check("t6_held_count", 64'(o_fifo_count), 64'd64);
    axis_out_tready = 1'b1;
    tick();
    check("t6_drop_valid", 64'(axis_out_tvalid), 64'd0);
    check("t6_idle", 64'(o_busy), 64'd0);
    check("t6_count", 64'(o_fifo_count), 64'd0);
    check("t6_nbeats", 64'(got_d.size()), 64'd1);
    check("t6_beat", got_d.size() > 0 ? got_d[0] : 64'd0, w0);
    repeat (2) tick();

    // run falls mid-frame: frame still completes
    for (int i = 0; i < 64; i++) load(8'($urandom), 1'b0);
    got_d.delete();
    got_l.delete();
    i_run = 1'b1;
    repeat (3) tick();
    i_run = 1'b0;
    wait_idle("t7_idle");
    compare_frame("t7");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
